scan_chain_master: RTL and testbench

//  On-chip driver for the two-phase scan chain: takes a parallel word from a host,

---
 rtl/scan_pkg.sv | 13 +
 rtl/scan_phase_gen.sv | 40 ++++
 rtl/scan_chain_master.sv | 134 +++++++++++++
 tb/tb_scan_chain_master.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types for the scan chain master: FSM states, scan-pair phases and a
// counter-width helper.
package scan_pkg;

  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, UPDATE, RESP} state_t;
  typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

  // Counter width that stays >= 1 even when the count range is a single value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_phase_gen.sv
// Phase sequencer for one scan clock pair: PHASE_CYCLES clocks per phase, four
// phases per pair, with a pair_done strobe on the final cycle of P3.
module scan_phase_gen
  import scan_pkg::*;
#(
  parameter int PHASE_CYCLES = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   restart,
  output phase_t phase,
  output logic   phase_last,
  output logic   pair_done
);

  localparam int            CW   = cnt_w(PHASE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign phase_last = (cnt == LAST);
  assign pair_done  = en && phase_last && (phase == P3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= P0;
    end else if (!en || restart) begin
      cnt   <= '0;
      phase <= P0;
    end else if (phase_last) begin
      cnt   <= '0;
      phase <= phase_t'(phase + 2'd1);
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/scan_chain_master.sv
// Two-phase scan chain driver: capture / shift / update sequencing with
// registered, non-overlapping clk1/clk2. Optional SCAN_MASTER_IRQ_EN adds done_irq/irq_clr.
module scan_chain_master
  import scan_pkg::*;
#(
  parameter int NUM_SCAN_BITS = 36,
  parameter int PHASE_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_capture,
  input  logic                     req_update,
  input  logic [NUM_SCAN_BITS-1:0] req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [NUM_SCAN_BITS-1:0] rsp_data,
  output logic                     sc_clk1,
  output logic                     sc_clk2,
  output logic                     sc_scan_in,
  output logic                     sc_capture,
  output logic                     sc_update,
`ifdef SCAN_MASTER_IRQ_EN
  output logic                     done_irq,
  input  logic                     irq_clr,
`endif
  input  logic                     sc_scan_out
);

  localparam int            N        = NUM_SCAN_BITS;
  localparam int            BW       = $clog2(N);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  state_t        state, state_next;
  phase_t        phase;
  logic          phase_last, pair_done;
  logic          active, accept;
  logic          cap_q, upd_q;
  logic [BW-1:0] bit_cnt;
  logic [N-1:0]  tx_sh, rx_sh;

  assign active = (state == CAPTURE) || (state == SHIFT) || (state == UPDATE);
  assign accept = (state == IDLE) && req_valid && req_ready;

  scan_phase_gen #(.PHASE_CYCLES(PHASE_CYCLES)) u_phase (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (active),
    .restart    (state_next != state),
    .phase      (phase),
    .phase_last (phase_last),
    .pair_done  (pair_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_capture ? CAPTURE : SHIFT;
      CAPTURE: if (pair_done) state_next = SHIFT;
      SHIFT:   if (pair_done && bit_cnt == LAST_BIT) state_next = upd_q ? UPDATE : RESP;
      UPDATE:  if (pair_done) state_next = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, outgoing word (MSB first) and incoming word (LSB in).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q   <= 1'b0;
      upd_q   <= 1'b0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
    end else if (accept) begin
      cap_q   <= req_capture;
      upd_q   <= req_update;
      bit_cnt <= '0;
      tx_sh   <= req_data;
    end else if (state == SHIFT) begin
      if (phase == P0 && phase_last) rx_sh <= {rx_sh[N-2:0], sc_scan_out};
      if (pair_done) begin
        tx_sh <= {tx_sh[N-2:0], 1'b0};
        if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

  assign rsp_data = rx_sh;

  // Handshake outputs are registered so they track state one cycle late,
  // which also keeps req_ready low while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state == RESP) && !(rsp_valid && rsp_ready);
    end
  end

  // Scan-side outputs all come straight from flops, so no decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_clk1    <= 1'b0;
      sc_clk2    <= 1'b0;
      sc_scan_in <= 1'b0;
      sc_capture <= 1'b0;
      sc_update  <= 1'b0;
    end else begin
      sc_clk1    <= (state == CAPTURE || state == SHIFT) && (phase == P1);
      sc_clk2    <= active && (phase == P3);
      sc_scan_in <= (state == SHIFT) && tx_sh[N-1];
      sc_capture <= (state == CAPTURE);
      sc_update  <= (state == UPDATE);
    end
  end

`ifdef SCAN_MASTER_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 done_irq <= 1'b0;
    else if (state_next == RESP && state != RESP) done_irq <= 1'b1;
    else if (irq_clr)                           done_irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_scan_chain_master.sv
// Directed bench for scan_chain_master with a two-phase scan chain model and a
// response scoreboard queue.
module tb_scan_chain_master;

  localparam int N  = 36;
  localparam int PC = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_capture, req_update;
  logic [N-1:0] req_data;
  logic         rsp_valid, rsp_ready;
  logic [N-1:0] rsp_data;
  logic         sc_clk1, sc_clk2, sc_scan_in, sc_capture, sc_update, sc_scan_out;
`ifdef SCAN_MASTER_IRQ_EN
  logic         done_irq;
  logic         irq_clr = 1'b0;
`endif

  always #5 clk = ~clk;

  scan_chain_master #(.NUM_SCAN_BITS(N), .PHASE_CYCLES(PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_capture (req_capture),
    .req_update  (req_update),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .sc_clk1     (sc_clk1),
    .sc_clk2     (sc_clk2),
    .sc_scan_in  (sc_scan_in),
    .sc_capture  (sc_capture),
    .sc_update   (sc_update),
`ifdef SCAN_MASTER_IRQ_EN
    .done_irq    (done_irq),
    .irq_clr     (irq_clr),
`endif
    .sc_scan_out (sc_scan_out)
  );

  // Chain model: clk1 loads masters (shift or parallel capture), clk2 moves
  // masters to slaves; clk2 with update copies slaves to the update register.
  logic [N-1:0] master = '0, slave = '0, upd_reg = '0, par_in = '0;
  always @(posedge sc_clk1) master <= sc_capture ? par_in : {slave[N-2:0], sc_scan_in};
  always @(posedge sc_clk2) begin
    slave <= master;
    if (sc_update) upd_reg <= slave;
  end
  assign sc_scan_out = slave[N-1];

  int overlap = 0;
  always @(sc_clk1 or sc_clk2) if (sc_clk1 && sc_clk2) overlap++;

  int total = 0, fails = 0;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [N-1:0] d, input logic cap, input logic upd);
    int w = 0;
    while (!req_ready && w < 100) begin @(posedge clk); #1; w++; end
    chk("req_ready_before", req_ready, 1);
    req_valid = 1'b1; req_data = d; req_capture = cap; req_update = upd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("req_ready_busy", req_ready, 0);
  endtask

  task automatic get_rsp(input string tag, input int exp_lat, input int hold);
    int lat = 0, unstable = 0;
    logic [N-1:0] d0;
    while (!rsp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_valid"}, rsp_valid, 1);
    d0 = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_data !== d0 || req_ready) unstable++;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, unstable, 0);
    chk({tag, "_data"}, rsp_data, exp_q.pop_front());
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, rsp_valid, 0);
    chk({tag, "_ready_back"}, req_ready, 1);
  endtask

  initial begin
    int stray;
    rst_n = 1'b0; req_valid = 1'b0; req_capture = 1'b0; req_update = 1'b0;
    req_data = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sc", {sc_clk1, sc_clk2, sc_scan_in, sc_capture, sc_update}, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_req_ready", req_ready, 1);

    // Write with update: chain was all zeros beforehand
    exp_q.push_back('0);
    do_req(36'h9_A5A5_A5A5, 1'b0, 1'b1);
    get_rsp("wr_upd", 4*PC*(N+1)+1, 0);
    chk("wr_upd_reg", upd_reg, 36'h9_A5A5_A5A5);
    chk("wr_chain", slave, 36'h9_A5A5_A5A5);

    // Capture read, no update
    par_in = 36'hF_0F0F_0F0F;
    exp_q.push_back(36'hF_0F0F_0F0F);
    do_req(36'h1_2345_6789, 1'b1, 1'b0);
    get_rsp("cap_rd", 4*PC*(N+1)+1, 0);
    chk("cap_upd_unchanged", upd_reg, 36'h9_A5A5_A5A5);

    // Back-to-back plain shifts return previous chain contents
    exp_q.push_back(36'h1_2345_6789);
    do_req(36'h1, 1'b0, 1'b0);
    get_rsp("b2b_1", 4*PC*N+1, 0);
    exp_q.push_back(36'h1);
    do_req(36'h2, 1'b0, 1'b0);
    get_rsp("b2b_2", 4*PC*N+1, 0);

    // Backpressure: response held 20 cycles
    exp_q.push_back(36'h2);
    do_req(36'hABC, 1'b0, 1'b1);
    get_rsp("bp", 4*PC*(N+1)+1, 20);
    chk("bp_upd_reg", upd_reg, 36'hABC);

    // Reset in the middle of SHIFT aborts without a response
    do_req(36'hF_FFFF_FFFF, 1'b0, 1'b0);
    repeat (50) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_sc", {sc_clk1, sc_clk2, sc_scan_in, sc_capture, sc_update}, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_req_ready", req_ready, 1);
    stray = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (rsp_valid || sc_clk1 || sc_clk2) stray++;
    end
    chk("abort_quiet", stray, 0);

    // Recovery after abort: capture read of a fresh pattern
    par_in = 36'h5_5AA5_3C3C;
    exp_q.push_back(36'h5_5AA5_3C3C);
    do_req('0, 1'b1, 1'b0);
    get_rsp("recover", 4*PC*(N+1)+1, 0);

    chk("clk_overlap", overlap, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
